// File: rtl/seg_access_arbiter.sv
// Segment register file sequencer/arbiter: EU writes, EU address generation and BIU prefetch.
// Define SEG_ARB_RR_EN for round-robin arbitration; otherwise fixed priority wr > eu > pf.
//
// state | meaning
// IDLE  | waiting; arbitrate and latch the winner's operands
// WRITE | write latched data into the latched segment register
// READ  | read the latched segment register
// CALC  | form segment*16 + offset into the owner's address register
// DONE  | pulse the owner's done
module seg_access_arbiter #(
    parameter int SEG_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    input  logic [1:0]         wr_sel,
    input  logic [SEG_W-1:0]   wr_data,
    output logic               wr_done,
    input  logic               eu_req,
    input  logic [1:0]         eu_sel,
    input  logic [SEG_W-1:0]   eu_offset,
    output logic               eu_done,
    output logic [SEG_W+3:0]   eu_addr,
    input  logic               pf_req,
    input  logic [SEG_W-1:0]   pf_offset,
    output logic               pf_done,
    output logic [SEG_W+3:0]   pf_addr,
    output logic               seg_write_en,
    output logic [1:0]         seg_reg_select,
    output logic [SEG_W-1:0]   seg_data,
    input  logic [SEG_W-1:0]   seg_rdata,
    output logic               busy
);
    localparam int ADDR_W = SEG_W + 4;

    typedef enum logic [2:0] {IDLE, WRITE, READ, CALC, DONE} state_t;
    typedef enum logic [1:0] {OWN_WR = 2'd0, OWN_EU = 2'd1, OWN_PF = 2'd2} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, gnt;
    logic              gnt_valid;
    logic [1:0]        lat_sel;
    logic [SEG_W-1:0]  lat_data;
    logic [SEG_W-1:0]  lat_offset;
    logic [ADDR_W-1:0] calc_addr;

`ifdef SEG_ARB_RR_EN
    // rr_ptr names the requester that currently has highest priority
    owner_t rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= OWN_WR;
        end else if (state == IDLE && gnt_valid) begin
            case (gnt)
                OWN_WR:  rr_ptr <= OWN_EU;
                OWN_EU:  rr_ptr <= OWN_PF;
                default: rr_ptr <= OWN_WR;
            endcase
        end
    end

    always_comb begin
        gnt_valid = wr_req | eu_req | pf_req;
        gnt       = OWN_WR;
        case (rr_ptr)
            OWN_WR: begin
                if (wr_req)      gnt = OWN_WR;
                else if (eu_req) gnt = OWN_EU;
                else             gnt = OWN_PF;
            end
            OWN_EU: begin
                if (eu_req)      gnt = OWN_EU;
                else if (pf_req) gnt = OWN_PF;
                else             gnt = OWN_WR;
            end
            default: begin
                if (pf_req)      gnt = OWN_PF;
                else if (wr_req) gnt = OWN_WR;
                else             gnt = OWN_EU;
            end
        endcase
    end
`else
    always_comb begin
        gnt_valid = wr_req | eu_req | pf_req;
        gnt       = OWN_WR;
        if (wr_req)      gnt = OWN_WR;
        else if (eu_req) gnt = OWN_EU;
        else             gnt = OWN_PF;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = (gnt == OWN_WR) ? WRITE : READ;
            WRITE:   state_nxt = DONE;
            READ:    state_nxt = CALC;
            CALC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Carry out of the top bit is dropped so addresses wrap at 1 MiB
    assign calc_addr = {seg_rdata, 4'h0} + {4'h0, lat_offset};

    assign seg_write_en   = (state == WRITE);
    assign seg_reg_select = lat_sel;
    assign seg_data       = lat_data;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_WR;
            lat_sel    <= '0;
            lat_data   <= '0;
            lat_offset <= '0;
            wr_done    <= 1'b0;
            eu_done    <= 1'b0;
            pf_done    <= 1'b0;
            eu_addr    <= '0;
            pf_addr    <= '0;
        end else begin
            state   <= state_nxt;
            wr_done <= (state == WRITE);
            eu_done <= (state == CALC) && (owner == OWN_EU);
            pf_done <= (state == CALC) && (owner == OWN_PF);
            if (state == IDLE && gnt_valid) begin
                owner <= gnt;
                case (gnt)
                    OWN_WR: begin
                        lat_sel  <= wr_sel;
                        lat_data <= wr_data;
                    end
                    OWN_EU: begin
                        lat_sel    <= eu_sel;
                        lat_offset <= eu_offset;
                    end
                    default: begin
                        lat_sel    <= 2'b00;
                        lat_offset <= pf_offset;
                    end
                endcase
            end
            if (state == CALC) begin
                if (owner == OWN_EU) eu_addr <= calc_addr;
                else                 pf_addr <= calc_addr;
            end
        end
    end
endmodule

// File: tb/tb_seg_access_arbiter.sv
// Scoreboard bench for seg_access_arbiter with a behavioural segment file and arbitration model.
module tb_seg_access_arbiter;
    localparam int SEG_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0, eu_req = 1'b0, pf_req = 1'b0;
    logic [1:0]  wr_sel = '0, eu_sel = '0;
    logic [15:0] wr_data = '0, eu_offset = '0, pf_offset = '0;
    logic        wr_done, eu_done, pf_done;
    logic [19:0] eu_addr, pf_addr;
    logic        seg_write_en;
    logic [1:0]  seg_reg_select;
    logic [15:0] seg_data;
    logic [15:0] seg_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   wq_sel[$], wq_data[$], eq_sel[$], eq_off[$], pq_off[$];
    int   seg_m[4];
    int   rr_p = 0;

    seg_access_arbiter #(.SEG_W(SEG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_done(wr_done),
        .eu_req(eu_req), .eu_sel(eu_sel), .eu_offset(eu_offset), .eu_done(eu_done), .eu_addr(eu_addr),
        .pf_req(pf_req), .pf_offset(pf_offset), .pf_done(pf_done), .pf_addr(pf_addr),
        .seg_write_en(seg_write_en), .seg_reg_select(seg_reg_select), .seg_data(seg_data),
        .seg_rdata(seg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Segment file: write on the clock edge, registered read data
    logic [15:0] seg_file [4];
    always @(posedge clk) begin
        if (seg_write_en) seg_file[seg_reg_select] <= seg_data;
        seg_rdata <= seg_file[seg_reg_select];
    end

    function automatic int addr_of(input int s, input int o);
        return (s * 16 + o) % (1 << 20);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_done(input int kind, input int val);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected kind=%0d actual=0x%0h required=none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_order_addr actual kind=%0d addr=0x%0h busy=%0b required kind=%0d addr=0x%0h busy=1",
                         kind, val, busy, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_done) check_done(0, 0);
            if (eu_done) check_done(1, int'(eu_addr));
            if (pf_done) check_done(2, int'(pf_addr));
        end
    end

    // Grant order from the arbitration rule: every requester with work left is pending
    task automatic model_burst();
        int   n[3];
        int   iw, ie, ip, w;
        exp_t e;
        iw = 0; ie = 0; ip = 0;
        n[0] = wq_sel.size(); n[1] = eq_sel.size(); n[2] = pq_off.size();
        while (n[0] + n[1] + n[2] > 0) begin
`ifdef SEG_ARB_RR_EN
            w = -1;
            for (int k = 0; k < 3; k++)
                if (w < 0 && n[(rr_p + k) % 3] > 0) w = (rr_p + k) % 3;
            rr_p = (w + 1) % 3;
`else
            w = (n[0] > 0) ? 0 : ((n[1] > 0) ? 1 : 2);
`endif
            n[w]--;
            e.kind = w;
            e.val  = 0;
            if (w == 0) begin
                seg_m[wq_sel[iw]] = wq_data[iw];
                iw++;
            end else if (w == 1) begin
                e.val = addr_of(seg_m[eq_sel[ie]], eq_off[ie]);
                ie++;
            end else begin
                e.val = addr_of(seg_m[0], pq_off[ip]);
                ip++;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic apply(input int k);
        if (k == 0) begin
            wr_sel = 2'(wq_sel[0]); wr_data = 16'(wq_data[0]); wr_req = 1'b1;
        end else if (k == 1) begin
            eu_sel = 2'(eq_sel[0]); eu_offset = 16'(eq_off[0]); eu_req = 1'b1;
        end else begin
            pf_offset = 16'(pq_off[0]); pf_req = 1'b1;
        end
    endtask

    // Drives the queued operands; each requester re-requests in the IDLE cycle after its done
    task automatic run_burst(output int lat);
        int rem[3];
        bit rearm[3];
        int cyc;
        cyc = 0;
        lat = -1;
        rem[0] = wq_sel.size(); rem[1] = eq_sel.size(); rem[2] = pq_off.size();
        model_burst();
        for (int k = 0; k < 3; k++) begin
            rearm[k] = 1'b0;
            if (rem[k] > 0) apply(k);
        end
        while ((rem[0] + rem[1] + rem[2] > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (rearm[k]) apply(k);
                rearm[k] = 1'b0;
            end
            if (wr_done && wr_req) begin
                void'(wq_sel.pop_front()); void'(wq_data.pop_front());
                rem[0]--; wr_req = 1'b0; rearm[0] = (rem[0] > 0);
                if (lat < 0) lat = cyc;
            end
            if (eu_done && eu_req) begin
                void'(eq_sel.pop_front()); void'(eq_off.pop_front());
                rem[1]--; eu_req = 1'b0; rearm[1] = (rem[1] > 0);
                if (lat < 0) lat = cyc;
            end
            if (pf_done && pf_req) begin
                void'(pq_off.pop_front());
                rem[2]--; pf_req = 1'b0; rearm[2] = (rem[2] > 0);
                if (lat < 0) lat = cyc;
            end
        end
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL burst_timeout actual=%0d required=0 pending", rem[0] + rem[1] + rem[2]);
            wr_req = 1'b0; eu_req = 1'b0; pf_req = 1'b0;
            wq_sel.delete(); wq_data.delete(); eq_sel.delete(); eq_off.delete(); pq_off.delete();
        end
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int lat;
        int t;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", int'({busy, wr_done, eu_done, pf_done, seg_write_en, seg_reg_select}), 0);
        check("reset_addrs", int'(eu_addr | pf_addr), 0);
        check("reset_seg_data", int'(seg_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wq_sel.push_back(0); wq_data.push_back(16'h1234);
        run_burst(lat);
        check("write_latency", lat, 2);
        pq_off.push_back(16'h0005);
        run_burst(lat);
        check("read_latency", lat, 3);

        wq_sel.push_back(1); wq_data.push_back(16'hFFFF);
        run_burst(lat);
        eq_sel.push_back(1); eq_off.push_back(16'h0010);
        run_burst(lat);

        wq_sel.push_back(2); wq_data.push_back(int'($urandom_range(0, 65535)));
        wq_sel.push_back(3); wq_data.push_back(int'($urandom_range(0, 65535)));
        run_burst(lat);

        wq_sel.push_back(0); wq_data.push_back(16'hABCD);
        eq_sel.push_back(2); eq_off.push_back(16'h1000);
        pq_off.push_back(16'hFFF0);
        run_burst(lat);

        for (int i = 0; i < 4; i++) begin
            wq_sel.push_back(int'($urandom_range(0, 3))); wq_data.push_back(int'($urandom_range(0, 65535)));
            eq_sel.push_back(int'($urandom_range(0, 3))); eq_off.push_back(int'($urandom_range(0, 65535)));
            pq_off.push_back(int'($urandom_range(0, 65535)));
        end
        run_burst(lat);

        for (int it = 0; it < 15; it++) begin
            int nw, ne, np;
            nw = int'($urandom_range(0, 3)); ne = int'($urandom_range(0, 3)); np = int'($urandom_range(0, 3));
            if (nw + ne + np == 0) ne = 1;
            for (int j = 0; j < nw; j++) begin
                wq_sel.push_back(int'($urandom_range(0, 3))); wq_data.push_back(int'($urandom_range(0, 65535)));
            end
            for (int j = 0; j < ne; j++) begin
                eq_sel.push_back(int'($urandom_range(0, 3))); eq_off.push_back(int'($urandom_range(0, 65535)));
            end
            for (int j = 0; j < np; j++) pq_off.push_back(int'($urandom_range(0, 65535)));
            run_burst(lat);
        end

        // Operands changed while in READ must not affect the result
        eq_sel.push_back(1); eq_off.push_back(16'h0001);
        model_burst();
        eq_sel.delete(); eq_off.delete();
        eu_sel = 2'd1; eu_offset = 16'h0001; eu_req = 1'b1;
        @(negedge clk);
        eu_offset = 16'h00FF; eu_sel = 2'd3;
        t = 0;
        while (!eu_done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("offset_change_done_seen", int'(eu_done), 1);
        eu_req = 1'b0;
        @(negedge clk);
        check("offset_change_drained", exp_q.size(), 0);
        exp_q.delete();

        // Reset during CALC discards the request; the re-issued one completes
        eu_sel = 2'd0; eu_offset = 16'h0777; eu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_in_calc", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("reset_in_calc_outputs",
              int'({busy, wr_done, eu_done, pf_done, seg_write_en, seg_reg_select}), 0);
        check("reset_in_calc_addrs", int'(eu_addr | pf_addr), 0);
        check("reset_in_calc_data", int'(seg_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_p = 0;
        eq_sel.push_back(0); eq_off.push_back(16'h0777);
        run_burst(lat);
        check("reissue_latency", lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
